lut_cfg_sequencer: RTL
======================

LUT_CFG_SEQUENCER -- requirements
Module: lut_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter INIT_W, default 16, giving the LUT INIT word width (legal values 2..64).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, ports as listed below.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low.
REQ-005 req0_valid  input  1  requester 0 has an INIT word pending.
REQ-006 req0_init  input  INIT_W  requester 0 INIT word.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle when req0_valid is also 1.
REQ-008 req1_valid  input  1  requester 1 has an INIT word pending.
REQ-009 req1_init  input  INIT_W  requester 1 INIT word.
REQ-010 req1_ready  output  1  requester 1 word accepted this cycle when req1_valid is also 1.
REQ-011 cfg_en  output  1  serial configuration strobe to the shared LUT config chain.
REQ-012 cfg_sdata  output  1  serial INIT bit, MSB first.
REQ-013 cfg_last  output  1  marks the final INIT bit.
REQ-014 lut_enable  output  1  LUT evaluation enable to the datapath.
REQ-015 busy  output  1  a configuration is in progress.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 done_id  output  1  requester index of the completed configuration; valid while done=1.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-019 In IDLE, reqX_ready SHALL be driven combinationally 1 for exactly one requester X with reqX_valid=1, and both readys SHALL be 0 outside IDLE.
REQ-020 When only one requester is valid in IDLE, that requester SHALL be selected.
REQ-021 When both are valid in IDLE, the requester not granted last SHALL be selected (round robin), and after reset requester 0 SHALL have priority.
REQ-022 The round-robin pointer SHALL update only on an accepted handshake (valid&ready).
REQ-023 On a handshake in cycle T, the block SHALL capture reqX_init into a shift register, record X, and enter SHIFT at T+1.
REQ-024 In SHIFT, the block SHALL hold cfg_en=1 for exactly INIT_W consecutive cycles (T+1..T+INIT_W), with cfg_sdata = init[INIT_W-1-k] in shift cycle k.
REQ-025 cfg_last SHALL be 1 only in shift cycle INIT_W-1; cfg_en, cfg_sdata and cfg_last SHALL be 0 outside SHIFT.
REQ-026 A down-counter sized ceil(log2(INIT_W)) bits SHALL count the shift cycles, and SHIFT SHALL exit to DONE after cycle INIT_W-1.
REQ-027 In DONE (cycle T+INIT_W+1), done SHALL be 1 with done_id=X, and the FSM SHALL return to IDLE unconditionally at T+INIT_W+2.
REQ-028 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-029 lut_enable SHALL go to 0 from T+1 through the DONE cycle, and SHALL be 1 in IDLE once at least one configuration has completed since reset.
REQ-030 Input word or valid changes after the handshake SHALL have no effect on the configuration in progress.
REQ-031 Requests arriving during SHIFT or DONE SHALL be held off with ready=0 and arbitrated on return to IDLE.
REQ-032 The minimum spacing between successive handshakes SHALL be INIT_W+2 cycles.

Reset
REQ-033 When rst=0, the block SHALL asynchronously set the state to IDLE, set the pointer to favour requester 0, clear the shift register, counter and configured flag, and drive all outputs to 0, with ready following REQ-019 from IDLE.
REQ-034 A reset asserted mid-SHIFT SHALL abort the transfer immediately with cfg_en=0 and no done pulse, and lut_enable SHALL stay 0 until a later configuration completes.

Verification
REQ-035 The bench SHALL reset, then apply req0_valid=1 with init=16'hA5C3 -> req0_ready=1 same cycle; cfg_sdata over 16 cfg_en cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; cfg_last on the 16th; done=1, done_id=0 at T+17; lut_enable=1 at T+18.
REQ-036 The bench SHALL hold both valid continuously after reset -> grants alternate 0,1,0,1 with handshakes 18 cycles apart.
REQ-037 The bench SHALL assert req1_valid alone, then toggle req1_init during SHIFT -> the serial stream matches the captured word and req1_ready stays 0 until IDLE.
REQ-038 The bench SHALL pull rst low at shift cycle 7 -> cfg_en=0, busy=0, lut_enable=0 with no done pulse; after release, req0 wins a simultaneous request.
REQ-039 The bench SHALL run with INIT_W=4 and init=4'b1001 -> exactly 4 cfg_en cycles with bits 1,0,0,1, and done at T+5.

Source files
------------

// File: rtl/lut_cfg_req_if.sv
// ----------------------------------------------------------------------------
// lut_cfg_req_if
// Request bundle between two INIT-word requesters and the LUT config
// sequencer.
//   req0_valid / req1_valid : requester has an INIT word pending
//   req0_init  / req1_init  : INIT word, INIT_W bits
//   req0_ready / req1_ready : sequencer accepts the word this cycle
// The master modport is the requester side. The slave modport is the
// sequencer side.
// ----------------------------------------------------------------------------
interface lut_cfg_req_if #(
    parameter int INIT_W = 16
) ();
    logic              req0_valid;
    logic [INIT_W-1:0] req0_init;
    logic              req0_ready;
    logic              req1_valid;
    logic [INIT_W-1:0] req1_init;
    logic              req1_ready;

    modport master (
        output req0_valid, req0_init, req1_valid, req1_init,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_init, req1_valid, req1_init,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/lut_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// lut_cfg_sequencer
// Arbitrates between two requesters and shifts the selected INIT word onto a
// shared serial LUT configuration chain, MSB first. The arbiter is round robin
// and gives requester 0 priority after reset.
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous reset, active low
//   req        : request bundle (valid/init/ready for requesters 0 and 1)
//   cfg_en     : serial configuration strobe, high for INIT_W cycles
//   cfg_sdata  : serial INIT bit
//   cfg_last   : marks the final INIT bit
//   lut_enable : LUT evaluation enable. It is high in IDLE after at least one
//                completed configuration.
//   busy       : a configuration is in progress (SHIFT or DONE)
//   done       : one-cycle completion pulse
//   done_id    : requester index of the completed configuration
// ----------------------------------------------------------------------------
module lut_cfg_sequencer #(
    parameter int INIT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    lut_cfg_req_if.slave       req,
    output logic               cfg_en,
    output logic               cfg_sdata,
    output logic               cfg_last,
    output logic               lut_enable,
    output logic               busy,
    output logic               done,
    output logic               done_id
);
    localparam int CNT_W = (INIT_W > 2) ? $clog2(INIT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INIT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [INIT_W-1:0] shift_r;
    logic [INIT_W-1:0] shift_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nx_s;
    logic              id_r;
    logic              id_nx_s;
    logic              prio_r;          // 1: requester 1 wins a tie
    logic              prio_nx_s;
    logic              configured_r;
    logic              configured_nx_s;
    logic              grant0_s;
    logic              grant1_s;

    logic              cfg_en_r;
    logic              cfg_sdata_r;
    logic              cfg_last_r;
    logic              lut_enable_r;
    logic              busy_r;
    logic              done_r;
    logic              done_id_r;
    logic              cfg_en_nx_s;
    logic              cfg_sdata_nx_s;
    logic              cfg_last_nx_s;
    logic              lut_enable_nx_s;
    logic              busy_nx_s;
    logic              done_nx_s;
    logic              done_id_nx_s;

    // Round-robin grant. It is only offered in IDLE and is combinational
    // from valid.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            if (req.req0_valid && req.req1_valid) begin
                if (prio_r) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b1;
                end
            end else begin
                grant0_s = req.req0_valid;
                grant1_s = req.req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req.req0_ready = grant0_s;
    assign req.req1_ready = grant1_s;

    // Next-state, datapath and pointer update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_nx_s      = state_r;
        shift_nx_s      = shift_r;
        cnt_nx_s        = cnt_r;
        id_nx_s         = id_r;
        prio_nx_s       = prio_r;
        configured_nx_s = configured_r;
        case (state_r)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_nx_s = SHIFT;
                    shift_nx_s = grant1_s ? req.req1_init : req.req0_init;
                    cnt_nx_s   = CNT_LOAD;
                    id_nx_s    = grant1_s;
                    // The other requester wins the next tie.
                    prio_nx_s  = grant0_s;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                shift_nx_s = {shift_r[INIT_W-2:0], 1'b0};
                if (cnt_r == CNT_ZERO) begin
                    state_nx_s = DONE;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    cnt_nx_s   = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                state_nx_s      = IDLE;
                shift_nx_s      = '0;
                configured_nx_s = 1'b1;
            end
            default: begin
                state_nx_s = IDLE;
                shift_nx_s = '0;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the next cycle. They are decoded from the next state
    // so the output flops line up exactly with the state they describe.
    always_comb begin
        cfg_en_nx_s     = (state_nx_s == SHIFT);
        cfg_sdata_nx_s  = cfg_en_nx_s & shift_nx_s[INIT_W-1];
        cfg_last_nx_s   = cfg_en_nx_s & (cnt_nx_s == CNT_ZERO);
        done_nx_s       = (state_nx_s == DONE);
        done_id_nx_s    = done_nx_s & id_nx_s;
        busy_nx_s       = (state_nx_s != IDLE);
        lut_enable_nx_s = (state_nx_s == IDLE) & configured_nx_s;
    end

    // State, datapath and registered outputs. A reset aborts any transfer
    // immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            shift_r      <= '0;
            cnt_r        <= CNT_ZERO;
            id_r         <= 1'b0;
            prio_r       <= 1'b0;
            configured_r <= 1'b0;
            cfg_en_r     <= 1'b0;
            cfg_sdata_r  <= 1'b0;
            cfg_last_r   <= 1'b0;
            lut_enable_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            done_id_r    <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            shift_r      <= shift_nx_s;
            cnt_r        <= cnt_nx_s;
            id_r         <= id_nx_s;
            prio_r       <= prio_nx_s;
            configured_r <= configured_nx_s;
            cfg_en_r     <= cfg_en_nx_s;
            cfg_sdata_r  <= cfg_sdata_nx_s;
            cfg_last_r   <= cfg_last_nx_s;
            lut_enable_r <= lut_enable_nx_s;
            busy_r       <= busy_nx_s;
            done_r       <= done_nx_s;
            done_id_r    <= done_id_nx_s;
        end
    end

    assign cfg_en     = cfg_en_r;
    assign cfg_sdata  = cfg_sdata_r;
    assign cfg_last   = cfg_last_r;
    assign lut_enable = lut_enable_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign done_id    = done_id_r;

endmodule
